// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the two-port sp_ram arbiter and its round-robin helper.
package sp_ram_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The pointer names the port that won the last contested cycle.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_ptr
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_ptr == PORT1) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Only a contested cycle moves the pointer; uncontested grants leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PORT1;
        end else if (i_en && (i_req == 2'b11)) begin
            r_ptr <= w_gnt[1];
        end
    end

    assign o_gnt = w_gnt;
    assign o_ptr = r_ptr;

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one registered-read sp_ram between two valid/ready requesters, with an optional clear pass after reset.
// Handshake: a request transfers on the rising edge where valid && ready; ready is combinational, never waits on ready.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INIT_EN  = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_data,
    output logic              p0_req_ready,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_data,

    input  logic              p1_req_valid,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_data,
    output logic              p1_req_ready,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_data,

    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,

    output logic              init_done,
    output state_t            dbg_state
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam state_t          RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_init_done;
    logic              r_rd_pend;
    logic              r_rd_port;
    logic [1:0]        r_resp_valid;

    logic [1:0]        w_gnt;
    logic              w_ptr;
    logic              w_run;
    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_run = (r_state == ST_RUN);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_run),
        .i_req ({p1_req_valid, p0_req_valid}),
        .o_gnt (w_gnt),
        .o_ptr (w_ptr)
    );

    assign w_any  = |w_gnt;
    assign w_sel  = w_gnt[1];
    assign w_we   = w_sel ? p1_req_we   : p0_req_we;
    assign w_addr = w_sel ? p1_req_addr : p0_req_addr;
    assign w_data = w_sel ? p1_req_data : p0_req_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RST_STATE;
            r_cnt        <= '0;
            r_init_done  <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_port    <= PORT0;
            r_resp_valid <= 2'b00;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
        end else begin
            // The RAM captures the read one edge after the request is registered; flag it at that same edge.
            r_resp_valid <= 2'b00;
            if (r_rd_pend) begin
                r_resp_valid[r_rd_port] <= 1'b1;
            end
            r_rd_pend <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    ram_we   <= 1'b1;
                    ram_addr <= r_cnt[ADDR_W-1:0];
                    ram_data <= INIT_VAL;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_init_done <= 1'b1;
                    if (w_any) begin
                        ram_we    <= w_we;
                        ram_addr  <= w_addr;
                        ram_data  <= w_data;
                        r_rd_pend <= !w_we;
                        r_rd_port <= w_sel;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign p0_req_ready  = w_gnt[0];
    assign p1_req_ready  = w_gnt[1];
    assign p0_resp_valid = r_resp_valid[0];
    assign p1_resp_valid = r_resp_valid[1];
    assign p0_resp_data  = ram_q;
    assign p1_resp_data  = ram_q;
    assign init_done     = r_init_done;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: drives both ports, models the sp_ram, and scoreboards read responses per port.
module tb_sp_ram_arbiter;
    import sp_ram_arb_pkg::*;

    localparam int         DW    = 8;
    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] IV    = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [AW-1:0] p0_req_addr = '0;
    logic [DW-1:0] p0_req_data = '0;
    logic          p0_req_ready, p0_resp_valid;
    logic [DW-1:0] p0_resp_data;
    logic          p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [AW-1:0] p1_req_addr = '0;
    logic [DW-1:0] p1_req_data = '0;
    logic          p1_req_ready, p1_resp_valid;
    logic [DW-1:0] p1_resp_data;
    logic [DW-1:0] ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we, init_done;
    state_t        dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int            lat0_q[$];
    int            lat1_q[$];
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] ram_mem[DEPTH];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_EN(1), .INIT_VAL(IV)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_data(p0_req_data), .p0_req_ready(p0_req_ready),
        .p0_resp_valid(p0_resp_valid), .p0_resp_data(p0_resp_data),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_data(p1_req_data), .p1_req_ready(p1_req_ready),
        .p1_resp_valid(p1_resp_valid), .p1_resp_data(p1_resp_data),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
        .init_done(init_done), .dbg_state(dbg_state)
    );

    // sp_ram: registered read, read-before-write
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    // scoreboard: pop on every response and compare data and arrival cycle
    always @(negedge clk) begin
        logic [DW-1:0] e;
        int            l;
        if (rst_n && p0_resp_valid) begin
            checks++;
            if (exp0_q.size() == 0) begin
                failures++;
                $display("FAIL p0_unexpected_resp data=%h cyc=%0d", p0_resp_data, cyc);
            end else begin
                e = exp0_q.pop_front();
                l = lat0_q.pop_front();
                if (p0_resp_data !== e || cyc != l) begin
                    failures++;
                    $display("FAIL p0_resp data=%h cyc=%0d required data=%h cyc=%0d", p0_resp_data, cyc, e, l);
                end
            end
        end
        if (rst_n && p1_resp_valid) begin
            checks++;
            if (exp1_q.size() == 0) begin
                failures++;
                $display("FAIL p1_unexpected_resp data=%h cyc=%0d", p1_resp_data, cyc);
            end else begin
                e = exp1_q.pop_front();
                l = lat1_q.pop_front();
                if (p1_resp_data !== e || cyc != l) begin
                    failures++;
                    $display("FAIL p1_resp data=%h cyc=%0d required data=%h cyc=%0d", p1_resp_data, cyc, e, l);
                end
            end
        end
    end

    // driver tasks
    task automatic accept(input int port, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (we) begin
            ref_mem[addr] = data;
        end else if (port == 0) begin
            exp0_q.push_back(ref_mem[addr]);
            lat0_q.push_back(cyc + 2);
        end else begin
            exp1_q.push_back(ref_mem[addr]);
            lat1_q.push_back(cyc + 2);
        end
    endtask

    task automatic drive_req(input int port, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int tries = 0;
        @(negedge clk);
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_data = data;
            p1_req_valid = 1'b0;
        end else begin
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_data = data;
            p0_req_valid = 1'b0;
        end
        #1;
        while (!(port == 0 ? p0_req_ready : p1_req_ready) && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
        end
        checks++;
        if (tries >= 20) begin
            failures++;
            $display("FAIL req_timeout port=%0d ready=0 required=1", port);
        end else begin
            accept(port, we, addr, data);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_resp pending p0=%0d p1=%0d required 0", name, exp0_q.size(), exp1_q.size());
        end
    endtask

    // Call right after rst_n is released on a negedge.
    task automatic check_init_pass(input string name);
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== AW'(k - 1) || ram_data !== IV) begin
                failures++;
                $display("FAIL %s_init_write k=%0d we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                         name, k, ram_we, ram_addr, ram_data, k - 1, IV);
            end
            checks++;
            if (init_done !== (k == DEPTH) || (dbg_state == ST_RUN) != (k == DEPTH)) begin
                failures++;
                $display("FAIL %s_init_done k=%0d init_done=%b state=%0d required init_done=%b",
                         name, k, init_done, dbg_state, k == DEPTH);
            end
            if (k <= 8) begin
                checks++;
                if (p0_req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_ready_in_init k=%0d ready=%b required 0", name, k, p0_req_ready);
                end
            end
            if (k == 8) p0_req_valid = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = IV;
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        p0_req_valid = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_data !== '0 || p0_resp_valid !== 1'b0 ||
            p1_resp_valid !== 1'b0 || init_done !== 1'b0 || p0_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state we=%b addr=%0d data=%h rv=%b%b done=%b rdy=%b required all 0",
                     ram_we, ram_addr, ram_data, p1_resp_valid, p0_resp_valid, init_done, p0_req_ready);
        end
        p0_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_init_pass("reset");
    endtask

    task automatic test_init_readback();
        for (int a = 0; a < DEPTH; a++) drive_req(1, 1'b0, AW'(a), '0);
        idle();
        drain("init_readback");
    endtask

    task automatic test_write_read_p0();
        drive_req(0, 1'b1, 4'd4, 8'h3C);
        drive_req(0, 1'b0, 4'd4, '0);
        idle();
        drain("write_read_p0");
    endtask

    task automatic test_dual_rr();
        logic want_p0;
        drive_req(0, 1'b1, 4'd1, 8'h11);
        drive_req(0, 1'b1, 4'd2, 8'h22);
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 4'd1;
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            want_p0 = (i % 2 == 0);
            checks++;
            if (p0_req_ready !== want_p0 || p1_req_ready !== !want_p0) begin
                failures++;
                $display("FAIL dual_grant i=%0d rdy0=%b rdy1=%b required rdy0=%b rdy1=%b",
                         i, p0_req_ready, p1_req_ready, want_p0, !want_p0);
            end
            if (p0_req_ready) accept(0, 1'b0, 4'd1, '0);
            else if (p1_req_ready) accept(1, 1'b0, 4'd2, '0);
            @(negedge clk);
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        drain("dual_rr");
    endtask

    task automatic test_cross_port();
        drive_req(1, 1'b1, 4'd9, 8'h77);
        drive_req(0, 1'b0, 4'd9, '0);
        idle();
        drain("cross_port");
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < DEPTH; a++) drive_req(1, 1'b1, AW'(a), DW'($urandom_range(0, 255)));
        for (int a = 0; a < DEPTH; a++) drive_req(0, 1'b0, AW'(a), '0);
        idle();
        drain("back_to_back");
    endtask

    task automatic test_reset_midread();
        drive_req(0, 1'b0, 4'd3, '0);
        @(negedge clk);
        rst_n = 1'b0;
        p0_req_valid = 1'b0;
        exp0_q.delete(); lat0_q.delete(); exp1_q.delete(); lat1_q.delete();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0 || ram_we !== 1'b0 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL midread_reset i=%0d rv=%b%b we=%b done=%b required 0",
                         i, p1_resp_valid, p0_resp_valid, ram_we, init_done);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        check_init_pass("midread");
        test_init_readback();
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_readback();
        test_write_read_p0();
        test_dual_rr();
        test_cross_port();
        test_back_to_back();
        test_reset_midread();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Shares one sp_ram instance (registered read, q <= mem[addr] on posedge clk, write when we=1) between two requesters using valid/ready request handshakes and fixed-latency read responses. After reset the block optionally sequences an initialisation pass that writes INIT_VAL to every RAM address. It then round-robin arbitrates between the two ports. The block sits between the two requesters and the sp_ram instance; sp_ram is the only RAM-side consumer.

Parameters:
DATA_W, 8, RAM data width
ADDR_W, 4, RAM address width; depth = 2**ADDR_W
INIT_EN, 1, 1 = run the clear pass after reset; 0 = go straight to RUN
INIT_VAL, 0, DATA_W-bit value written to every address during init

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
p0_req_valid  in  1  port 0 request valid
p0_req_we  in  1  port 0: 1 = write, 0 = read
p0_req_addr  in  ADDR_W  port 0 address
p0_req_data  in  DATA_W  port 0 write data
p0_req_ready  out  1  port 0 request accepted this cycle
p0_resp_valid  out  1  port 0 read data valid
p0_resp_data  out  DATA_W  port 0 read data
p1_*  same seven signals for port 1
ram_data  out  DATA_W  to sp_ram data
ram_addr  out  ADDR_W  to sp_ram addr
ram_we  out  1  to sp_ram we
ram_q  in  DATA_W  from sp_ram q
init_done  out  1  high once RUN is entered

Behaviour:
- Reset (async, rst_n=0):
  - Registered outputs: ram_we=0, ram_addr=0, ram_data=0, p*_resp_valid=0, init_done=0.
  - State = INIT (INIT_EN=1) or RUN (INIT_EN=0); init counter = 0; rr pointer = port 1, so port 0 wins the first tie.
- States:
  - INIT: each cycle registers ram_we=1, ram_addr=cnt, ram_data=INIT_VAL, then increments cnt. After the cycle with cnt = 2**ADDR_W-1, go to RUN and set init_done=1. The pass takes exactly 2**ADDR_W cycles. p*_req_ready=0 throughout INIT.
  - RUN: remains in RUN until reset.
- Arbitration (RUN only):
  - p*_req_ready is combinational: high for exactly the granted port, and only when its valid is high.
  - Only one port valid: that port is granted.
  - Both valid: grant the port that is not the rr pointer, then update the pointer to the granted port. The pointer is unchanged when nothing is granted.
  - At most one grant per cycle. A request transfers on the edge where valid & ready are both high.
  - Requesters hold their request signals stable while valid & !ready.
- RAM-side stage:
  - On the acceptance edge N, register ram_we/ram_addr/ram_data from the granted request.
  - With no grant: ram_we=0; ram_addr and ram_data hold their previous values.
  - Track rd_pend = granted & !we, plus rd_port.
- Read response:
  - sp_ram captures at edge N+1. At that edge px_resp_valid is registered to 1 for rd_port, for one cycle.
  - px_resp_data = ram_q, combinational pass-through for both ports. It is meaningful only while resp_valid is high.
  - Latency: resp_valid is high in the 2nd cycle after the acceptance cycle. Fixed latency, no response backpressure; requesters must accept.
- Throughput: one request per cycle total. Back-to-back reads pipeline, and responses return in acceptance order.
- Same-address write then read, either port, in consecutive accepted cycles: the read returns the new data because the RAM is in-order.
- Reset mid-INIT or mid-read: the pending response is dropped (resp_valid=0), and INIT restarts from address 0.
- Address wrap: no wrap logic is needed in RUN. In INIT the counter is ADDR_W+1 bits wide, so the terminal count is unambiguous.

Decomposition:
- Shared package sp_ram_arb_pkg:
  - state enum (INIT, RUN)
  - port index constants (PORT0=0, PORT1=1)
  - default DATA_W/ADDR_W localparams
- Sub-module rr_arb2: a 2-requester round-robin grant with its pointer register, reused by other shared-resource blocks.

Test Plan:
- INIT_EN=1, INIT_VAL=8'hA5, no requests → init_done rises after exactly 16 cycles. Every later read of addresses 0..15 returns 8'hA5.
- Port 0 writes 8'h3C to addr 4, then port 0 reads addr 4 → p0_resp_valid high 2 cycles after the read acceptance, p0_resp_data=8'h3C, p1_resp_valid stays 0.
- Both ports hold valid reads (p0 addr 1, p1 addr 2) for 4 cycles → grants alternate p0,p1,p0,p1. Responses alternate ports with the matching data, and no grant is lost or duplicated.
- p1 writes 8'h77 to addr 9 and p0 reads addr 9 in the very next accepted cycle → p0_resp_data=8'h77.
- 16 back-to-back port 0 reads of addrs 0..15 after the writes → 16 consecutive resp_valid cycles, with data in address order.
- Assert rst_n=0 one cycle after a read acceptance → no resp_valid appears, ram_we=0 during reset, and INIT reruns from addr 0 (init_done=0 until completion).
